// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_pkg
// Brief    : Shared command encodings, I/O addresses and FSM states for io_bus_ctrl.
// Revision : 1.0
// ============================================================================
package io_bus_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAM_ISSUE = 2'd1,
        RAM_CAPT  = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM      = 2'd0,
        RGN_LED      = 2'd1,
        RGN_SW       = 2'd2,
        RGN_UNMAPPED = 2'd3
    } region_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchronizer for asynchronous level inputs.
// Revision : 1.0
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/io_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_ctrl
// Brief    : CPU memory-bus controller: RAM window, LED register, switch port.
// Revision : 1.0
// ============================================================================
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              err
);

    state_t             r_state;
    state_t             w_state_nxt;
    region_t            w_region;
    logic [7:0]         w_sw_sync;
    logic               w_is_read;
    logic               w_is_write;
    logic               w_accept;

    logic [DATA_W-1:0]  r_read_data;
    logic [7:0]         r_ledr;
    logic [RAM_AW-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_ram_we;
    logic               r_err;

    sync2 #(
        .WIDTH (8)
    ) u_sw_sync (
        .clk (clk),
        .rst (reset),
        .i_d (sw),
        .o_q (w_sw_sync)
    );

    // Upper address bit clear selects the RAM window; the rest is sparse I/O.
    always_comb begin
        w_region = RGN_UNMAPPED;
        if (!mem_addr[ADDR_W-1]) begin
            w_region = RGN_RAM;
        end else if (mem_addr == ADDR_W'(LED_ADDR)) begin
            w_region = RGN_LED;
        end else if (mem_addr == ADDR_W'(SW_ADDR)) begin
            w_region = RGN_SW;
        end
    end

    assign w_is_read  = (mem_cmd == CMD_READ);
    assign w_is_write = (mem_cmd == CMD_WRITE);
    assign w_accept   = (r_state == IDLE) && (w_is_read || w_is_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_is_read && (w_region == RGN_RAM)) ? RAM_ISSUE : RESP;
                end
            end
            RAM_ISSUE: w_state_nxt = RAM_CAPT;
            RAM_CAPT:  w_state_nxt = RESP;
            RESP:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // ram_we is a one-shot: only a RAM write accept raises it, for the RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
            r_ledr      <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_we    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            if (w_accept) begin
                case (w_region)
                    RGN_RAM: begin
                        r_ram_addr <= mem_addr[RAM_AW-1:0];
                        if (w_is_write) begin
                            r_ram_din <= write_data;
                            r_ram_we  <= 1'b1;
                        end
                    end
                    RGN_LED: begin
                        if (w_is_write) begin
                            r_ledr <= write_data[7:0];
                        end else begin
                            r_read_data <= {{(DATA_W-8){1'b0}}, r_ledr};
                        end
                    end
                    RGN_SW: begin
                        if (w_is_read) begin
                            r_read_data <= {{(DATA_W-8){1'b0}}, w_sw_sync};
                        end
                    end
                    default: begin
                        r_err <= 1'b1;
                        if (w_is_read) begin
                            r_read_data <= '0;
                        end
                    end
                endcase
            end
            if (r_state == RAM_CAPT) begin
                r_read_data <= ram_dout;
            end
        end
    end

    assign read_data = r_read_data;
    assign mem_ready = (r_state == RESP);
    assign ledr      = r_ledr;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_ctrl
// Brief    : Directed self-checking bench for io_bus_ctrl with a behavioural sync RAM.
// Revision : 1.0
// ============================================================================
module tb_io_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [7:0]  sw;
    logic [7:0]  ledr;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic        err;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int rdy_cnt = 0;

    logic [15:0] ram_mem [256];

    io_bus_ctrl #(
        .ADDR_W (9),
        .DATA_W (16),
        .RAM_AW (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .sw         (sw),
        .ledr       (ledr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we)    we_cnt++;
        if (mem_ready) rdy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command for one cycle, then wait (bounded) for mem_ready.
    // Returns in the mem_ready cycle; lat counts cycles after the accept cycle.
    task automatic do_cmd(input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] wd, output int lat);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
        step();
        mem_cmd = 2'b00;
        lat = 1;
        while (!mem_ready && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data: got %h expected %h", read_data, 16'h0000); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected %b", mem_ready, 1'b0); end
        checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL reset_ledr: got %h expected %h", ledr, 8'h00); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected %b", ram_we, 1'b0); end
        checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL reset_ram_addr: got %h expected %h", ram_addr, 8'h00); end
        checks++; if (ram_din !== 16'h0000) begin errors++; $display("FAIL reset_ram_din: got %h expected %h", ram_din, 16'h0000); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_ram();
        int lat;
        int we0;
        we0 = we_cnt;
        do_cmd(2'b10, 9'h005, 16'hBEEF, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ram_wr_latency: got %0d expected %0d", lat, 1); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_wr_we: got %b expected %b", ram_we, 1'b1); end
        checks++; if (ram_addr !== 8'h05) begin errors++; $display("FAIL ram_wr_addr: got %h expected %h", ram_addr, 8'h05); end
        checks++; if (ram_din !== 16'hBEEF) begin errors++; $display("FAIL ram_wr_din: got %h expected %h", ram_din, 16'hBEEF); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL ram_wr_read_data_hold: got %h expected %h", read_data, 16'h0000); end
        step();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_wr_we_drop: got %b expected %b", ram_we, 1'b0); end
        checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL ram_wr_we_cycles: got %0d expected %0d", we_cnt - we0, 1); end
        do_cmd(2'b01, 9'h005, 16'h0000, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ram_rd_latency: got %0d expected %0d", lat, 3); end
        checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_data: got %h expected %h", read_data, 16'hBEEF); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_rd_we: got %b expected %b", ram_we, 1'b0); end
        step();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ram_rd_ready_single: got %b expected %b", mem_ready, 1'b0); end
    endtask

    task automatic test_led();
        int lat;
        do_cmd(2'b10, 9'h100, 16'h12A5, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL led_wr_latency: got %0d expected %0d", lat, 1); end
        checks++; if (ledr !== 8'hA5) begin errors++; $display("FAIL led_wr_ledr: got %h expected %h", ledr, 8'hA5); end
        checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL led_wr_read_data_hold: got %h expected %h", read_data, 16'hBEEF); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL led_wr_ram_we: got %b expected %b", ram_we, 1'b0); end
        step();
        do_cmd(2'b01, 9'h100, 16'h0000, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL led_rd_latency: got %0d expected %0d", lat, 1); end
        checks++; if (read_data !== 16'h00A5) begin errors++; $display("FAIL led_rd_data: got %h expected %h", read_data, 16'h00A5); end
        step();
    endtask

    task automatic test_switch();
        int lat;
        sw = 8'h3C;
        repeat (3) step();
        do_cmd(2'b01, 9'h140, 16'h0000, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_rd_latency: got %0d expected %0d", lat, 1); end
        checks++; if (read_data !== 16'h003C) begin errors++; $display("FAIL sw_rd_data: got %h expected %h", read_data, 16'h003C); end
        step();
        sw = 8'hFF;
        step();
        do_cmd(2'b01, 9'h140, 16'h0000, lat);
        checks++; if (read_data !== 16'h003C) begin errors++; $display("FAIL sw_rd_sync_delay: got %h expected %h", read_data, 16'h003C); end
        step();
        repeat (3) step();
        do_cmd(2'b01, 9'h140, 16'h0000, lat);
        checks++; if (read_data !== 16'h00FF) begin errors++; $display("FAIL sw_rd_new: got %h expected %h", read_data, 16'h00FF); end
        step();
        do_cmd(2'b10, 9'h140, 16'h1234, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_wr_latency: got %0d expected %0d", lat, 1); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_wr_err: got %b expected %b", err, 1'b0); end
        checks++; if (read_data !== 16'h00FF) begin errors++; $display("FAIL sw_wr_read_data_hold: got %h expected %h", read_data, 16'h00FF); end
        checks++; if (ledr !== 8'hA5) begin errors++; $display("FAIL sw_wr_ledr: got %h expected %h", ledr, 8'hA5); end
        step();
    endtask

    task automatic test_unmapped();
        int lat;
        int r0;
        do_cmd(2'b01, 9'h1F0, 16'h0000, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL unm_rd_latency: got %0d expected %0d", lat, 1); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL unm_rd_data: got %h expected %h", read_data, 16'h0000); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL unm_rd_err: got %b expected %b", err, 1'b1); end
        step();
        do_cmd(2'b10, 9'h1C0, 16'h0077, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL unm_wr_latency: got %0d expected %0d", lat, 1); end
        checks++; if (ledr !== 8'hA5) begin errors++; $display("FAIL unm_wr_ledr: got %h expected %h", ledr, 8'hA5); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL unm_wr_ram_we: got %b expected %b", ram_we, 1'b0); end
        step();
        do_cmd(2'b01, 9'h005, 16'h0000, lat);
        checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL unm_after_ram_rd: got %h expected %h", read_data, 16'hBEEF); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL unm_err_sticky: got %b expected %b", err, 1'b1); end
        step();
        r0 = rdy_cnt;
        mem_cmd  = 2'b11;
        mem_addr = 9'h100;
        write_data = 16'h00C3;
        step();
        mem_cmd = 2'b00;
        repeat (4) step();
        checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL rsvd_cmd_ready: got %0d expected %0d", rdy_cnt - r0, 0); end
        checks++; if (ledr !== 8'hA5) begin errors++; $display("FAIL rsvd_cmd_ledr: got %h expected %h", ledr, 8'hA5); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat_io;
        logic [7:0] pat_ram;
        pat_io = '0;
        mem_cmd  = 2'b01;
        mem_addr = 9'h140;
        for (int i = 0; i < 6; i++) begin
            pat_io[i] = mem_ready;
            step();
        end
        mem_cmd = 2'b00;
        checks++; if (pat_io !== 6'b101010) begin errors++; $display("FAIL b2b_io_pattern: got %b expected %b", pat_io, 6'b101010); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_io_tail: got %b expected %b", mem_ready, 1'b0); end
        pat_ram = '0;
        mem_cmd  = 2'b01;
        mem_addr = 9'h005;
        for (int i = 0; i < 8; i++) begin
            pat_ram[i] = mem_ready;
            step();
        end
        mem_cmd = 2'b00;
        checks++; if (pat_ram !== 8'b10001000) begin errors++; $display("FAIL b2b_ram_pattern: got %b expected %b", pat_ram, 8'b10001000); end
        checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_ram_data: got %h expected %h", read_data, 16'hBEEF); end
        step();
    endtask

    task automatic test_reset_abort();
        int lat;
        int r0;
        r0 = rdy_cnt;
        mem_cmd  = 2'b01;
        mem_addr = 9'h005;
        step();
        mem_cmd = 2'b00;
        step();
        reset = 1'b1;
        step();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL abort_rd_ready: got %b expected %b", mem_ready, 1'b0); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL abort_rd_read_data: got %h expected %h", read_data, 16'h0000); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_rd_err_cleared: got %b expected %b", err, 1'b0); end
        checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL abort_rd_ledr: got %h expected %h", ledr, 8'h00); end
        checks++; if ({ram_addr, ram_din, ram_we} !== 25'h0) begin errors++; $display("FAIL abort_rd_ram_port: got %h expected %h", {ram_addr, ram_din, ram_we}, 25'h0); end
        reset = 1'b0;
        repeat (3) step();
        checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL abort_rd_no_pulse: got %0d expected %0d", rdy_cnt - r0, 0); end

        do_cmd(2'b10, 9'h100, 16'h0033, lat);
        checks++; if (ledr !== 8'h33) begin errors++; $display("FAIL abort_pre_ledr: got %h expected %h", ledr, 8'h33); end
        step();
        r0 = rdy_cnt;
        mem_cmd    = 2'b10;
        mem_addr   = 9'h100;
        write_data = 16'h005A;
        reset      = 1'b1;
        step();
        mem_cmd = 2'b00;
        reset   = 1'b0;
        checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL abort_wr_ledr: got %h expected %h", ledr, 8'h00); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL abort_wr_ready: got %b expected %b", mem_ready, 1'b0); end
        repeat (2) step();
        checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL abort_wr_no_pulse: got %0d expected %0d", rdy_cnt - r0, 0); end
        checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL abort_wr_ledr_after: got %h expected %h", ledr, 8'h00); end
        do_cmd(2'b01, 9'h140, 16'h0000, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL abort_idle_latency: got %0d expected %0d", lat, 1); end
        checks++; if (read_data !== 16'h00FF) begin errors++; $display("FAIL abort_idle_sw: got %h expected %h", read_data, 16'h00FF); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        sw         = 8'h00;
        #1;
        test_reset();
        test_ram();
        test_led();
        test_switch();
        test_unmapped();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
